add_sub_acc_n: RTL and testbench

- Registered, parametrised-width adder/subtractor with a valid/ready stream interface.
- Adds accumulate modes, optional signed saturation, and carry/overflow/zero/saturation status flags.
- Sits in the datapath between an operand source and a result consumer.
- Latency 1 cycle, throughput 1 operation per cycle, full backpressure support.

---
 rtl/add_sub_acc_n.sv | 104 ++++++++++
 tb/tb_add_sub_acc_n.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_acc_n.sv
// Registered N-bit add/subtract/accumulate unit with valid/ready handshake,
// optional signed saturation and carry/overflow/zero/saturation flags.
module add_sub_acc_n #(
   parameter int N      = 8,
   parameter bit SAT_EN = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   input  logic [1:0]   op_in,
   input  logic         sat_in,
   input  logic         clr_in,
   input  logic         in_valid_in,
   output logic         in_ready_o,
   output logic [N-1:0] ss_o,
   output logic         co_o,
   output logic         ov_o,
   output logic         z_o,
   output logic         sat_o,
   output logic         out_valid_o,
   input  logic         out_ready_in
);

   logic [N-1:0] r_acc;
   logic [N-1:0] r_ss;
   logic         r_co;
   logic         r_ov;
   logic         r_z;
   logic         r_sat;
   logic         r_valid;

   logic         w_accept;
   logic         w_acc_mode;
   logic         w_sub;
   logic [N-1:0] w_l;
   logic [N-1:0] w_r;
   logic [N:0]   w_wide;
   logic [N-1:0] w_raw;
   logic         w_ov;
   logic         w_do_sat;
   logic [N-1:0] w_clamp;
   logic [N-1:0] w_res;

   assign in_ready_o = !r_valid | out_ready_in;
   assign w_accept   = in_valid_in & in_ready_o;
   assign w_acc_mode = op_in[1];
   assign w_sub      = op_in[0];

   // A clear arriving with an accumulate op makes that op start from zero.
   assign w_l = w_acc_mode ? (clr_in ? '0 : r_acc) : a_in;
   assign w_r = w_acc_mode ? a_in : b_in;

   assign w_wide = w_sub ? ({1'b0, w_l} - {1'b0, w_r})
                         : ({1'b0, w_l} + {1'b0, w_r});
   assign w_raw  = w_wide[N-1:0];

   assign w_ov = w_sub
      ? ((w_l[N-1] != w_r[N-1]) & (w_raw[N-1] != w_l[N-1]))
      : ((w_l[N-1] == w_r[N-1]) & (w_raw[N-1] != w_l[N-1]));

   assign w_do_sat = SAT_EN & sat_in & w_ov;
   assign w_clamp  = w_l[N-1] ? {1'b1, {(N-1){1'b0}}}
                              : {1'b0, {(N-1){1'b1}}};
   assign w_res    = w_do_sat ? w_clamp : w_raw;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ss    <= '0;
         r_co    <= 1'b0;
         r_ov    <= 1'b0;
         r_z     <= 1'b0;
         r_sat   <= 1'b0;
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_ss    <= w_res;
         r_co    <= w_wide[N];
         r_ov    <= w_ov;
         r_z     <= (w_res == '0);
         r_sat   <= w_do_sat;
         r_valid <= 1'b1;
      end else if (out_ready_in) begin
         r_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
      end else if (w_accept & w_acc_mode) begin
         r_acc <= w_res;
      end else if (clr_in) begin
         r_acc <= '0;
      end
   end

   assign ss_o        = r_ss;
   assign co_o        = r_co;
   assign ov_o        = r_ov;
   assign z_o         = r_z;
   assign sat_o       = r_sat;
   assign out_valid_o = r_valid;

endmodule

// File: tb/tb_add_sub_acc_n.sv
// Self-checking bench for add_sub_acc_n (N=8, SAT_EN=1): vector table
// through a scoreboard queue plus backpressure/clear/reset sequences.
module tb_add_sub_acc_n;

   typedef struct {
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       sat;
      logic       clr;
      logic [7:0] ss;
      logic       co;
      logic       ov;
      logic       z;
      logic       so;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] a_in = '0;
   logic [7:0] b_in = '0;
   logic [1:0] op_in = '0;
   logic       sat_in = 1'b0;
   logic       clr_in = 1'b0;
   logic       in_valid_in = 1'b0;
   logic       in_ready_o;
   logic [7:0] ss_o;
   logic       co_o;
   logic       ov_o;
   logic       z_o;
   logic       sat_o;
   logic       out_valid_o;
   logic       out_ready_in = 1'b1;

   int   checks = 0;
   int   failures = 0;
   vec_t cur;
   vec_t q[$];
   vec_t tbl[16];

   add_sub_acc_n #(.N(8), .SAT_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .a_in(a_in), .b_in(b_in), .op_in(op_in),
      .sat_in(sat_in), .clr_in(clr_in),
      .in_valid_in(in_valid_in), .in_ready_o(in_ready_o),
      .ss_o(ss_o), .co_o(co_o), .ov_o(ov_o), .z_o(z_o),
      .sat_o(sat_o), .out_valid_o(out_valid_o),
      .out_ready_in(out_ready_in)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic sat,
                               input logic clr, input logic [7:0] ss,
                               input logic co, input logic ov,
                               input logic z, input logic so);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.sat = sat; v.clr = clr;
      v.ss = ss; v.co = co; v.ov = ov; v.z = z; v.so = so;
      return v;
   endfunction

   // Scoreboard: outputs pop at negedge before any new accept is pushed.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid_o && out_ready_in) begin
            if (q.size() == 0) begin
               chk("unexpected_output", 32'(ss_o), 32'hDEAD);
            end else begin
               vec_t e;
               e = q.pop_front();
               chk("ss", 32'(ss_o), 32'(e.ss));
               chk("co", 32'(co_o), 32'(e.co));
               chk("ov", 32'(ov_o), 32'(e.ov));
               chk("z", 32'(z_o), 32'(e.z));
               chk("sat", 32'(sat_o), 32'(e.so));
            end
         end
         if (in_valid_in && in_ready_o) q.push_back(cur);
      end
   end

   task automatic drive(input vec_t v);
      a_in = v.a; b_in = v.b; op_in = v.op;
      sat_in = v.sat; clr_in = v.clr;
      cur = v;
      in_valid_in = 1'b1;
   endtask

   task automatic send(input vec_t v);
      int n;
      drive(v);
      n = 0;
      @(negedge clk);
      while (!in_ready_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready_o) chk("accept_timeout", 32'(in_ready_o), 32'd1);
      @(posedge clk);
      #1;
      in_valid_in = 1'b0;
      clr_in = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() > 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      chk("drain_left", 32'(q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = mk(2'b00, 8'h7F, 8'h01, 0, 0, 8'h80, 0, 1, 0, 0);
      tbl[1]  = mk(2'b00, 8'h7F, 8'h01, 1, 0, 8'h7F, 0, 1, 0, 1);
      tbl[2]  = mk(2'b01, 8'h00, 8'h01, 0, 0, 8'hFF, 1, 0, 0, 0);
      tbl[3]  = mk(2'b01, 8'h80, 8'h01, 1, 0, 8'h80, 0, 1, 0, 1);
      tbl[4]  = mk(2'b00, 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0, 1, 0);
      tbl[5]  = mk(2'b10, 8'h10, 8'h00, 0, 1, 8'h10, 0, 0, 0, 0);
      tbl[6]  = mk(2'b10, 8'h10, 8'h00, 0, 0, 8'h20, 0, 0, 0, 0);
      tbl[7]  = mk(2'b10, 8'h10, 8'h00, 0, 0, 8'h30, 0, 0, 0, 0);
      tbl[8]  = mk(2'b11, 8'h30, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0);
      tbl[9]  = mk(2'b10, 8'h7F, 8'h00, 1, 0, 8'h7F, 0, 0, 0, 0);
      tbl[10] = mk(2'b10, 8'h01, 8'h00, 1, 0, 8'h7F, 0, 1, 0, 1);
      tbl[11] = mk(2'b10, 8'h00, 8'h00, 0, 0, 8'h7F, 0, 0, 0, 0);
      tbl[12] = mk(2'b11, 8'hFF, 8'h00, 0, 0, 8'h80, 1, 1, 0, 0);
      tbl[13] = mk(2'b00, 8'h12, 8'h34, 0, 0, 8'h46, 0, 0, 0, 0);
      tbl[14] = mk(2'b11, 8'h01, 8'h00, 1, 0, 8'h80, 0, 1, 0, 1);
      tbl[15] = mk(2'b10, 8'h80, 8'h00, 0, 0, 8'h00, 1, 1, 1, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(in_ready_o), 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid_o), 32'd0);
      chk("rst_ss", 32'(ss_o), 32'd0);
      chk("rst_flags", 32'({co_o, ov_o, z_o, sat_o}), 32'd0);

      // Back-to-back vector stream.
      for (int i = 0; i < 16; i++) send(tbl[i]);
      drain();

      // Backpressure: one accept, stall three cycles, then overlap.
      clr_in = 1'b1;
      @(posedge clk);
      #1;
      clr_in = 1'b0;
      out_ready_in = 1'b0;
      drive(mk(2'b10, 8'h01, 8'h00, 0, 0, 8'h01, 0, 0, 0, 0));
      @(negedge clk);
      #1;
      cur = mk(2'b10, 8'h01, 8'h00, 0, 0, 8'h02, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("bp_ready", 32'(in_ready_o), 32'd0);
         chk("bp_ss", 32'(ss_o), 32'h01);
         chk("bp_valid", 32'(out_valid_o), 32'd1);
      end
      out_ready_in = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready_o), 32'd1);
      @(posedge clk);
      #1;
      in_valid_in = 1'b0;
      chk("bp_overlap_ss", 32'(ss_o), 32'h02);
      drain();

      // Clear coinciding with an accumulate op, and a bare clear.
      send(mk(2'b10, 8'h40, 8'h00, 0, 1, 8'h40, 0, 0, 0, 0));
      send(mk(2'b10, 8'h05, 8'h00, 0, 1, 8'h05, 0, 0, 0, 0));
      send(mk(2'b10, 8'h00, 8'h00, 0, 0, 8'h05, 0, 0, 0, 0));
      drain();
      out_ready_in = 1'b0;
      send(mk(2'b00, 8'h11, 8'h22, 0, 0, 8'h33, 0, 0, 0, 0));
      clr_in = 1'b1;
      @(posedge clk);
      #1;
      clr_in = 1'b0;
      chk("clr_valid", 32'(out_valid_o), 32'd1);
      chk("clr_ss", 32'(ss_o), 32'h33);
      out_ready_in = 1'b1;
      send(mk(2'b10, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0));
      drain();

      // Reset with a pending result; input during reset is ignored.
      out_ready_in = 1'b0;
      send(mk(2'b10, 8'h30, 8'h00, 0, 1, 8'h30, 0, 0, 0, 0));
      chk("pre_rst_valid", 32'(out_valid_o), 32'd1);
      rst = 1'b1;
      out_ready_in = 1'b1;
      drive(mk(2'b10, 8'h55, 8'h00, 0, 0, 8'h55, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      in_valid_in = 1'b0;
      chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
      chk("mid_rst_ss", 32'(ss_o), 32'd0);
      chk("mid_rst_flags", 32'({co_o, ov_o, z_o, sat_o}), 32'd0);
      rst = 1'b0;
      q.delete();
      send(mk(2'b10, 8'h02, 8'h00, 0, 0, 8'h02, 0, 0, 0, 0));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
